word_memory_bank: RTL and testbench

//   Clocked, parametrised successor to the single-byte latch store: DEPTH words
//   of WIDTH bits, one synchronous write port and one registered read port.

---
 rtl/word_memory_bank.sv | 103 ++++++++++
 tb/tb_word_memory_bank.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/word_memory_bank.sv
// Purpose: DEPTH x WIDTH scratch store with one write port, one registered read port and a clear sequencer.
// Latency: reads return one cycle after rd_en; a clear keeps busy high for exactly DEPTH cycles.
// Backpressure: none; writes and reads are dropped while busy, and out-of-range writes are dropped.
module word_memory_bank #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data,
   output logic              rd_valid,
   input  logic              clear,
   output logic              busy
);

   typedef enum logic {IDLE, CLEAR} state_t;

   // The bound is one bit wider than the address so DEPTH == 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH-1);

   state_t            state;
   logic [ADDR_W-1:0] cnt;
   logic [WIDTH-1:0]  mem [DEPTH];
   logic              wr_ok;
   logic              rd_ok;

   assign wr_ok = ({1'b0, wr_addr} < DEPTH_X);
   assign rd_ok = ({1'b0, rd_addr} < DEPTH_X);

   // Clear sequencer: walks cnt across every word once, then returns to IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cnt <= '0;
               if (clear) begin
                  state <= CLEAR;
                  busy  <= 1'b1;
               end
            end
            CLEAR: begin
               if (cnt == LAST) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               cnt   <= '0;
            end
         endcase
      end
   end

   // Array update: the clear sequencer owns the array while running; otherwise in-range writes land.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (state == CLEAR) begin
         mem[cnt] <= '0;
      end else if (wr_en && wr_ok) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Registered read: write-first on an address collision, zero for out-of-range addresses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         if (state == IDLE && rd_en) begin
            rd_valid <= 1'b1;
            if (!rd_ok) begin
               rd_data <= '0;
            end else if (wr_en && wr_addr == rd_addr) begin
               rd_data <= wr_data;
            end else begin
               rd_data <= mem[rd_addr];
            end
         end
      end
   end

endmodule

// File: tb/tb_word_memory_bank.sv
// Bench for word_memory_bank: a 16-word and a 10-word instance share the same stimulus.
// Reads push expected data into per-instance queues; a negedge monitor pops and compares.
module tb_word_memory_bank;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       wr_en = 1'b0;
   logic       rd_en = 1'b0;
   logic       clear = 1'b0;
   logic [3:0] wr_addr = '0;
   logic [3:0] rd_addr = '0;
   logic [7:0] wr_data = '0;

   logic [7:0] rd_data16, rd_data10;
   logic       rd_valid16, rd_valid10, busy16, busy10;

   int vectors = 0;
   int miscompares = 0;
   logic [7:0] q16[$];
   logic [7:0] q10[$];

   word_memory_bank #(.WIDTH(8), .DEPTH(16), .ADDR_W(4)) u16 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data16), .rd_valid(rd_valid16),
      .clear(clear), .busy(busy16)
   );

   word_memory_bank #(.WIDTH(8), .DEPTH(10), .ADDR_W(4)) u10 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data10), .rd_valid(rd_valid10),
      .clear(clear), .busy(busy10)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every presented read result is matched against the oldest expectation.
   always @(negedge clk) begin
      if (rd_valid16 === 1'b1) begin
         if (q16.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL rd16_unexpected: rd_valid=1 data 0x%0h, expected no read at %0t", rd_data16, $time);
         end else begin
            chk("rd16", {24'h0, rd_data16}, {24'h0, q16.pop_front()});
         end
      end
      if (rd_valid10 === 1'b1) begin
         if (q10.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL rd10_unexpected: rd_valid=1 data 0x%0h, expected no read at %0t", rd_data10, $time);
         end else begin
            chk("rd10", {24'h0, rd_data10}, {24'h0, q10.pop_front()});
         end
      end
   end

   // One cycle of stimulus; e16/e10 are the hand-computed read results for each instance.
   task automatic op(input logic we, input logic [3:0] wa, input logic [7:0] wd,
                     input logic re, input logic [3:0] ra,
                     input logic [7:0] e16, input logic [7:0] e10, input logic clr);
      wr_en = we; wr_addr = wa; wr_data = wd;
      rd_en = re; rd_addr = ra; clear = clr;
      if (re) begin
         q16.push_back(e16);
         q10.push_back(e10);
      end
      @(posedge clk);
      #1;
      wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d);
      op(1'b1, a, d, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
   endtask

   task automatic rd(input logic [3:0] a, input logic [7:0] e16, input logic [7:0] e10);
      op(1'b0, 4'h0, 8'h00, 1'b1, a, e16, e10, 1'b0);
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (!busy16 && !busy10) done = 1'b1;
      end
      if (!done) chk("wait_idle_timeout", {30'h0, busy16, busy10}, 32'h0);
   endtask

   initial begin
      int n16;
      int n10;
      bit done;

      // Reset state, checked with no clock edge involved.
      #2 rst_n = 1'b0;
      #1;
      chk("rst_rd_data16", {24'h0, rd_data16}, 32'h0);
      chk("rst_rd_valid16", {31'h0, rd_valid16}, 32'h0);
      chk("rst_busy16", {31'h0, busy16}, 32'h0);
      chk("rst_rd_data10", {24'h0, rd_data10}, 32'h0);
      chk("rst_rd_valid10", {31'h0, rd_valid10}, 32'h0);
      chk("rst_busy10", {31'h0, busy10}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Every word reads back zero after reset.
      for (int a = 0; a < 16; a++) rd(4'(a), 8'h00, 8'h00);

      // Basic writes; address 15 is out of range for the 10-word instance.
      wr(4'd3, 8'hA5);
      wr(4'd15, 8'h3C);
      rd(4'd3, 8'hA5, 8'hA5);
      rd(4'd15, 8'h3C, 8'h00);
      rd(4'd4, 8'h00, 8'h00);

      // Write-first collision.
      wr(4'd5, 8'h11);
      op(1'b1, 4'd5, 8'h77, 1'b1, 4'd5, 8'h77, 8'h77, 1'b0);
      rd(4'd5, 8'h77, 8'h77);

      // Out-of-range behaviour on the 10-word instance; word 9 is its last.
      wr(4'd12, 8'h5A);
      rd(4'd12, 8'h5A, 8'h00);
      wr(4'd9, 8'h99);
      rd(4'd9, 8'h99, 8'h99);
      op(1'b1, 4'd10, 8'h66, 1'b1, 4'd10, 8'h66, 8'h00, 1'b0);

      // Fill with 0xFF, then clear while hammering writes, reads and clear.
      for (int a = 0; a < 16; a++) wr(4'(a), 8'hFF);
      rd(4'd7, 8'hFF, 8'hFF);
      rd(4'd12, 8'hFF, 8'h00);
      op(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, 8'h00, 1'b1);
      n16 = 0; n10 = 0; done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk);
         if (busy16) begin
            n16++;
            chk("rd_valid_while_busy", {31'h0, rd_valid16}, 32'h0);
         end
         if (busy10) n10++;
         if (!busy16 && !busy10) begin
            done = 1'b1;
         end else begin
            #1;
            if (busy16) begin
               wr_en = 1'b1; wr_addr = 4'(n16 - 1); wr_data = 8'hEE;
               rd_en = 1'b1; rd_addr = 4'(n16 - 1);
               clear = (n16 <= 9);
               // The 10-word instance is idle again for these reads, all out of its range.
               if (n16 >= 11) q10.push_back(8'h00);
            end else begin
               wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
            end
         end
      end
      wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
      chk("busy_cycles16", n16, 16);
      chk("busy_cycles10", n10, 10);
      for (int a = 0; a < 16; a++) rd(4'(a), 8'h00, 8'h00);

      // Write and clear in the same cycle: the clear erases the write.
      op(1'b1, 4'd2, 8'h42, 1'b0, 4'h0, 8'h00, 8'h00, 1'b1);
      wait_idle();
      rd(4'd2, 8'h00, 8'h00);

      // Reset in the middle of a clear.
      wr(4'd0, 8'h42);
      wr(4'd12, 8'h42);
      op(1'b0, 4'h0, 8'h00, 1'b0, 4'h0, 8'h00, 8'h00, 1'b1);
      repeat (7) @(negedge clk);
      chk("busy_mid_clear16", {31'h0, busy16}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_clear_busy16", {31'h0, busy16}, 32'h0);
      chk("rst_mid_clear_busy10", {31'h0, busy10}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      rd(4'd0, 8'h00, 8'h00);
      rd(4'd12, 8'h00, 8'h00);
      wr(4'd4, 8'h31);
      rd(4'd4, 8'h31, 8'h31);

      // Reset while a read result is being presented.
      wr(4'd1, 8'h42);
      rd(4'd1, 8'h42, 8'h42);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_read_rd_data16", {24'h0, rd_data16}, 32'h0);
      chk("rst_mid_read_rd_valid16", {31'h0, rd_valid16}, 32'h0);
      chk("rst_mid_read_rd_data10", {24'h0, rd_data10}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      rd(4'd1, 8'h00, 8'h00);
      chk("idle_after_reset", {31'h0, busy16}, 32'h0);

      repeat (2) @(negedge clk);
      chk("q16_drained", q16.size(), 0);
      chk("q10_drained", q10.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
